// File: rtl/jtcop_sndbus.sv
// Sound-CPU bus controller: SX-latched chip selects, registered read mux,
// command FIFO with NMI handshake. Optional NMI watchdog: JTCOP_NMI_WDOG_EN.
module jtcop_sndbus #(
    parameter int FIFO_AW = 3,
    parameter int NIRQ    = 2,
    parameter int WDOG_W  = 4,
    parameter int RAM_AW  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [20:0]       cpu_a,
    input  logic              cpu_sx,
    input  logic              cpu_ce,
    input  logic              cpu_wrn,
    input  logic              cpu_rdn,
    output logic [7:0]        cpu_din,
    output logic              waitn,
    output logic              nmi_n,
    output logic              irqn,
    input  logic [NIRQ-1:0]   irq_n,
    output logic              rom_cs,
    input  logic              rom_ok,
    input  logic [7:0]        rom_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    output logic              opl_cs,
    output logic              opn_cs,
    output logic              oki_cs,
    input  logic [7:0]        opl_dout,
    input  logic [7:0]        opn_dout,
    input  logic [7:0]        oki_dout,
    input  logic              snreq,
    input  logic [7:0]        latch,
    output logic              fifo_full,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              overflow,
    output logic [7:0]        status
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [1:0] {NMI_IDLE, NMI_ASSERT, NMI_GAP} nmi_state_t;

    logic [4:0] page;
    logic       half;
    logic       dec_rom, dec_opl, dec_opn, dec_oki, dec_cmd, dec_ram;
    logic       cmd_sel, ram_sel;
    logic       unused_addr;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]         last, head;
    logic               snreq_r, push, pop, push_ok, pop_ok, fifo_empty;
    logic [3:0]         lvl4;

    nmi_state_t state, nxt;
    logic       gap_cnt;
    logic       wd_expire;

    assign page        = cpu_a[20:16];
    assign half        = cpu_a[15];
    assign unused_addr = ^cpu_a;

    always_comb begin
        dec_rom = page == 5'h00;
        dec_opl = page == 5'h10 && half;
        dec_opn = page == 5'h11 && half;
        dec_oki = page == 5'h13 && !half;
        dec_cmd = page == 5'h13 && half;
        dec_ram = page == 5'h1F;
    end

    // A new address strobe takes precedence over the end-of-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_cs  <= 1'b0;
            opl_cs  <= 1'b0;
            opn_cs  <= 1'b0;
            oki_cs  <= 1'b0;
            cmd_sel <= 1'b0;
            ram_sel <= 1'b0;
        end else if (cpu_sx) begin
            rom_cs  <= dec_rom;
            opl_cs  <= dec_opl;
            opn_cs  <= dec_opn;
            oki_cs  <= dec_oki;
            cmd_sel <= dec_cmd;
            ram_sel <= dec_ram;
        end else if (cpu_ce) begin
            rom_cs  <= 1'b0;
            opl_cs  <= 1'b0;
            opn_cs  <= 1'b0;
            oki_cs  <= 1'b0;
            cmd_sel <= 1'b0;
            ram_sel <= 1'b0;
        end
    end

    assign ram_we   = ram_sel & ~cpu_wrn;
    assign ram_addr = cpu_a[RAM_AW-1:0];
    assign irqn     = &irq_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_din <= 8'hFF;
            waitn   <= 1'b1;
        end else begin
            waitn <= !rom_cs || rom_ok;
            if (ram_sel)      cpu_din <= ram_dout;
            else if (opn_cs)  cpu_din <= opn_dout;
            else if (opl_cs)  cpu_din <= opl_dout;
            else if (oki_cs)  cpu_din <= oki_dout;
            else if (cmd_sel) cpu_din <= head;
            else if (rom_cs)  cpu_din <= rom_data;
            else              cpu_din <= 8'hFF;
        end
    end

    // A pop frees a slot in the same cycle, so a push at full still lands
    assign fifo_empty = fifo_level == '0;
    assign fifo_full  = fifo_level == LVL_FULL;
    assign push       = snreq & ~snreq_r;
    assign pop        = cpu_ce & cmd_sel & ~cpu_rdn;
    assign pop_ok     = pop & ~fifo_empty;
    assign push_ok    = push & (~fifo_full | pop_ok);
    assign head       = fifo_empty ? last : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snreq_r    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            last       <= 8'h00;
        end else begin
            snreq_r <= snreq;
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                last   <= mem[rd_ptr];
            end
            if (push && !push_ok) overflow <= 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= latch;
    end

    generate
        if (FIFO_AW >= 3) begin : g_lvl_trunc
            assign lvl4 = fifo_level[3:0];
        end else begin : g_lvl_ext
            assign lvl4 = {{(3-FIFO_AW){1'b0}}, fifo_level};
        end
    endgenerate

    assign status = {nmi_n, irqn, overflow, fifo_full, lvl4};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= NMI_IDLE;
            gap_cnt <= 1'b0;
        end else begin
            state   <= nxt;
            gap_cnt <= (state == NMI_GAP) ? ~gap_cnt : 1'b0;
        end
    end

    always_comb begin
        nxt   = state;
        nmi_n = 1'b1;
        case (state)
            NMI_IDLE: begin
                if (!fifo_empty) nxt = NMI_ASSERT;
            end
            NMI_ASSERT: begin
                nmi_n = 1'b0;
                if (pop_ok || wd_expire) nxt = NMI_GAP;
            end
            NMI_GAP: begin
                if (gap_cnt) nxt = fifo_empty ? NMI_IDLE : NMI_ASSERT;
            end
            default: nxt = NMI_IDLE;
        endcase
    end

`ifdef JTCOP_NMI_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1);

    logic [WDOG_W-1:0] wdog;
    logic              irqn_r, irq_fall;

    assign irq_fall  = irqn_r & ~irqn;
    assign wd_expire = irq_fall && (wdog == WDOG_ONE);

    // Counts interrupt edges while the CPU ignores the NMI; reload on entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog   <= '1;
            irqn_r <= 1'b1;
        end else begin
            irqn_r <= irqn;
            if (state != NMI_ASSERT && nxt == NMI_ASSERT) begin
                wdog <= '1;
            end else if (state == NMI_ASSERT && irq_fall) begin
                wdog <= (wdog == WDOG_ONE) ? '1 : wdog - WDOG_ONE;
            end
        end
    end
`else
    localparam int unused_wdog_w = WDOG_W;
    assign wd_expire = 1'b0;
`endif

endmodule

// File: tb/tb_jtcop_sndbus.sv
// Directed self-checking bench for jtcop_sndbus (decode, FIFO, NMI, RAM).
module tb_jtcop_sndbus;
    localparam int FIFO_AW = 3;
    localparam int NIRQ    = 2;
    localparam int WDOG_W  = 4;
    localparam int RAM_AW  = 13;
    localparam logic [20:0] CMD_A = 21'h138000;

    logic              clk = 1'b0;
    logic              rst;
    logic [20:0]       cpu_a;
    logic              cpu_sx, cpu_ce, cpu_wrn, cpu_rdn;
    logic [7:0]        cpu_din;
    logic              waitn, nmi_n, irqn;
    logic [NIRQ-1:0]   irq_n;
    logic              rom_cs, rom_ok;
    logic [7:0]        rom_data;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_dout;
    logic              opl_cs, opn_cs, oki_cs;
    logic [7:0]        opl_dout, opn_dout, oki_dout;
    logic              snreq;
    logic [7:0]        latch;
    logic              fifo_full;
    logic [FIFO_AW:0]  fifo_level;
    logic              overflow;
    logic [7:0]        status;

    logic [7:0] tb_ram [1<<RAM_AW];
    logic [7:0] ram_wdata;
    int         we_count = 0;
    int         passed = 0;
    int         total = 0;

    always #5 clk = ~clk;

    jtcop_sndbus #(.FIFO_AW(FIFO_AW), .NIRQ(NIRQ), .WDOG_W(WDOG_W), .RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst(rst), .cpu_a(cpu_a), .cpu_sx(cpu_sx), .cpu_ce(cpu_ce),
        .cpu_wrn(cpu_wrn), .cpu_rdn(cpu_rdn), .cpu_din(cpu_din), .waitn(waitn),
        .nmi_n(nmi_n), .irqn(irqn), .irq_n(irq_n), .rom_cs(rom_cs), .rom_ok(rom_ok),
        .rom_data(rom_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout),
        .opl_cs(opl_cs), .opn_cs(opn_cs), .oki_cs(oki_cs), .opl_dout(opl_dout),
        .opn_dout(opn_dout), .oki_dout(oki_dout), .snreq(snreq), .latch(latch),
        .fifo_full(fifo_full), .fifo_level(fifo_level), .overflow(overflow), .status(status)
    );

    assign ram_dout = tb_ram[ram_addr];

    always @(posedge clk) begin
        if (ram_we) begin
            tb_ram[ram_addr] <= ram_wdata;
            we_count <= we_count + 1;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        cpu_sx = 1'b0; cpu_ce = 1'b0; cpu_wrn = 1'b1; cpu_rdn = 1'b1; snreq = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        latch = b; snreq = 1'b1;
        @(negedge clk);
        snreq = 1'b0;
    endtask

    task automatic cpu_cycle(input logic [20:0] addr, input bit wr, input int waits,
                             output logic [7:0] data, output logic [3:0] cs);
        @(negedge clk);
        cpu_a = addr; cpu_sx = 1'b1; cpu_wrn = !wr; cpu_rdn = wr;
        @(negedge clk);
        cpu_sx = 1'b0;
        cs = {rom_cs, opl_cs, opn_cs, oki_cs};
        repeat (waits) @(negedge clk);
        cpu_ce = 1'b1;
        @(negedge clk);
        cpu_ce = 1'b0; cpu_wrn = 1'b1; cpu_rdn = 1'b1;
        data = cpu_din;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({rom_cs, opl_cs, opn_cs, oki_cs, ram_we} !== 5'b0) $display("FAIL reset_sel: got %b want 00000", {rom_cs, opl_cs, opn_cs, oki_cs, ram_we}); else passed++;
        total++; if (cpu_din !== 8'hFF) $display("FAIL reset_din: got %h want ff", cpu_din); else passed++;
        total++; if ({waitn, nmi_n, irqn} !== 3'b111) $display("FAIL reset_wait_nmi_irq: got %b want 111", {waitn, nmi_n, irqn}); else passed++;
        total++; if ({fifo_level, fifo_full, overflow} !== 6'b0) $display("FAIL reset_fifo: got %b want 000000", {fifo_level, fifo_full, overflow}); else passed++;
        total++; if (status !== 8'hC0) $display("FAIL reset_status: got %h want c0", status); else passed++;
    endtask

    task automatic test_rom();
        rom_ok = 1'b0; rom_data = 8'h00;
        @(negedge clk);
        cpu_a = 21'h000123; cpu_sx = 1'b1; cpu_rdn = 1'b0;
        @(negedge clk);
        cpu_sx = 1'b0;
        total++; if (rom_cs !== 1'b1) $display("FAIL rom_cs_set: got %b want 1", rom_cs); else passed++;
        @(negedge clk);
        total++; if (waitn !== 1'b0) $display("FAIL rom_wait_low: got %b want 0", waitn); else passed++;
        rom_ok = 1'b1; rom_data = 8'h5A;
        @(negedge clk);
        total++; if (waitn !== 1'b1) $display("FAIL rom_wait_high: got %b want 1", waitn); else passed++;
        total++; if (cpu_din !== 8'h5A) $display("FAIL rom_data: got %h want 5a", cpu_din); else passed++;
        cpu_ce = 1'b1;
        @(negedge clk);
        cpu_ce = 1'b0; cpu_rdn = 1'b1;
        total++; if (rom_cs !== 1'b0) $display("FAIL rom_cs_clear: got %b want 0", rom_cs); else passed++;
    endtask

    task automatic test_decode();
        logic [20:0] addrs [6] = '{21'h108000, 21'h118000, 21'h130000, 21'h100000, 21'h120000, 21'h000000};
        logic [7:0]  exp_d [6] = '{8'h3C, 8'h4D, 8'h5E, 8'hFF, 8'hFF, 8'h5A};
        logic [3:0]  exp_c [6] = '{4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b1000};
        logic [7:0]  d;
        logic [3:0]  cs;
        for (int i = 0; i < 6; i++) begin
            cpu_cycle(addrs[i], 1'b0, 0, d, cs);
            total++; if (cs !== exp_c[i]) $display("FAIL decode_cs[%0d]: got %b want %b", i, cs, exp_c[i]); else passed++;
            total++; if (d !== exp_d[i]) $display("FAIL decode_data[%0d]: got %h want %h", i, d, exp_d[i]); else passed++;
        end
    endtask

    task automatic test_sx_priority();
        @(negedge clk);
        cpu_a = 21'h108000; cpu_sx = 1'b1; cpu_rdn = 1'b0;
        @(negedge clk);
        cpu_a = 21'h118000; cpu_ce = 1'b1;
        @(negedge clk);
        cpu_sx = 1'b0; cpu_ce = 1'b0;
        total++; if ({opl_cs, opn_cs} !== 2'b01) $display("FAIL sx_wins: got %b want 01", {opl_cs, opn_cs}); else passed++;
        cpu_ce = 1'b1;
        @(negedge clk);
        cpu_ce = 1'b0; cpu_rdn = 1'b1;
        total++; if ({opl_cs, opn_cs} !== 2'b00) $display("FAIL ce_clears: got %b want 00", {opl_cs, opn_cs}); else passed++;
    endtask

    task automatic test_ram();
        logic [7:0] d;
        logic [3:0] cs;
        int we0;
        we0 = we_count;
        ram_wdata = 8'hA5;
        cpu_cycle(21'h1F0010, 1'b1, 0, d, cs);
        cpu_cycle(21'h1F0010, 1'b0, 0, d, cs);
        total++; if (d !== 8'hA5) $display("FAIL ram_readback: got %h want a5", d); else passed++;
        total++; if (we_count - we0 !== 1) $display("FAIL ram_we_pulses: got %0d want 1", we_count - we0); else passed++;
        total++; if (ram_addr !== 13'h0010) $display("FAIL ram_addr: got %h want 0010", ram_addr); else passed++;
    endtask

    task automatic test_fifo_basic();
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] d;
        logic [3:0] cs;
        do_reset();
        for (int i = 0; i < 3; i++) push(exp[i]);
        total++; if (fifo_level !== 4'd3) $display("FAIL fifo_level3: got %0d want 3", fifo_level); else passed++;
        total++; if (nmi_n !== 1'b0) $display("FAIL nmi_assert: got %b want 0", nmi_n); else passed++;
        for (int i = 0; i < 3; i++) begin
            cpu_cycle(CMD_A, 1'b0, 0, d, cs);
            total++; if (d !== exp[i]) $display("FAIL cmd_read[%0d]: got %h want %h", i, d, exp[i]); else passed++;
            total++; if (nmi_n !== 1'b1) $display("FAIL nmi_gap0[%0d]: got %b want 1", i, nmi_n); else passed++;
            @(negedge clk);
            total++; if (nmi_n !== 1'b1) $display("FAIL nmi_gap1[%0d]: got %b want 1", i, nmi_n); else passed++;
            @(negedge clk);
            total++; if (nmi_n !== (i == 2)) $display("FAIL nmi_after_gap[%0d]: got %b want %b", i, nmi_n, (i == 2)); else passed++;
        end
        total++; if (fifo_level !== 4'd0) $display("FAIL fifo_drained: got %0d want 0", fifo_level); else passed++;
    endtask

    task automatic test_full_overflow();
        logic [7:0] d;
        logic [3:0] cs;
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        total++; if ({fifo_level, fifo_full, overflow} !== {4'd8, 1'b1, 1'b0}) $display("FAIL full8: got %b want 100010", {fifo_level, fifo_full, overflow}); else passed++;
        @(negedge clk);
        cpu_a = CMD_A; cpu_sx = 1'b1; cpu_rdn = 1'b0;
        @(negedge clk);
        cpu_sx = 1'b0; cpu_ce = 1'b1; latch = 8'h48; snreq = 1'b1;
        @(negedge clk);
        cpu_ce = 1'b0; cpu_rdn = 1'b1; snreq = 1'b0;
        d = cpu_din;
        total++; if (d !== 8'h40) $display("FAIL pushpop_data: got %h want 40", d); else passed++;
        total++; if ({fifo_level, fifo_full, overflow} !== {4'd8, 1'b1, 1'b0}) $display("FAIL pushpop_full: got %b want 100010", {fifo_level, fifo_full, overflow}); else passed++;
        push(8'h49);
        total++; if ({fifo_level, overflow} !== {4'd8, 1'b1}) $display("FAIL overflow: got %b want 10001", {fifo_level, overflow}); else passed++;
        total++; if (status[5:0] !== 6'b111000) $display("FAIL status_full: got %b want 111000", status[5:0]); else passed++;
        for (int i = 0; i < 8; i++) begin
            cpu_cycle(CMD_A, 1'b0, 0, d, cs);
            total++; if (d !== 8'h41 + 8'(i)) $display("FAIL drain[%0d]: got %h want %h", i, d, 8'h41 + 8'(i)); else passed++;
        end
        cpu_cycle(CMD_A, 1'b0, 0, d, cs);
        total++; if (d !== 8'h48) $display("FAIL empty_read: got %h want 48", d); else passed++;
        total++; if ({fifo_level, overflow} !== {4'd0, 1'b1}) $display("FAIL drained_sticky: got %b want 00001", {fifo_level, overflow}); else passed++;
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] d;
        logic [3:0] cs;
        push(8'h99);
        push(8'h9A);
        @(negedge clk);
        cpu_a = CMD_A; cpu_sx = 1'b1; cpu_rdn = 1'b0;
        @(negedge clk);
        cpu_sx = 1'b0; cpu_ce = 1'b1; rst = 1'b1;
        @(negedge clk);
        cpu_ce = 1'b0; cpu_rdn = 1'b1; rst = 1'b0;
        total++; if ({fifo_level, overflow, nmi_n} !== {4'd0, 1'b0, 1'b1}) $display("FAIL midreset_state: got %b want 000001", {fifo_level, overflow, nmi_n}); else passed++;
        cpu_cycle(CMD_A, 1'b0, 0, d, cs);
        total++; if (d !== 8'h00) $display("FAIL midreset_empty_read: got %h want 00", d); else passed++;
    endtask

    task automatic test_watchdog();
        do_reset();
        irq_n = 2'b10;
        #1;
        total++; if (irqn !== 1'b0) $display("FAIL irqn_low: got %b want 0", irqn); else passed++;
        irq_n = 2'b11;
        #1;
        total++; if (irqn !== 1'b1) $display("FAIL irqn_high: got %b want 1", irqn); else passed++;
        push(8'h77);
        @(negedge clk);
        total++; if (nmi_n !== 1'b0) $display("FAIL wd_nmi_start: got %b want 0", nmi_n); else passed++;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk); irq_n[0] = 1'b0;
            @(negedge clk); irq_n[0] = 1'b1;
        end
        total++; if (nmi_n !== 1'b0) $display("FAIL wd_nmi_14: got %b want 0", nmi_n); else passed++;
        @(negedge clk); irq_n[0] = 1'b0;
        @(negedge clk); irq_n[0] = 1'b1;
`ifdef JTCOP_NMI_WDOG_EN
        total++; if (nmi_n !== 1'b1) $display("FAIL wd_gap0: got %b want 1", nmi_n); else passed++;
        @(negedge clk);
        total++; if (nmi_n !== 1'b1) $display("FAIL wd_gap1: got %b want 1", nmi_n); else passed++;
        @(negedge clk);
        total++; if (nmi_n !== 1'b0) $display("FAIL wd_reassert: got %b want 0", nmi_n); else passed++;
`else
        total++; if (nmi_n !== 1'b0) $display("FAIL nowd_hold0: got %b want 0", nmi_n); else passed++;
        repeat (2) @(negedge clk);
        total++; if (nmi_n !== 1'b0) $display("FAIL nowd_hold2: got %b want 0", nmi_n); else passed++;
`endif
        total++; if (fifo_level !== 4'd1) $display("FAIL wd_level: got %0d want 1", fifo_level); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        cpu_a = '0; cpu_sx = 1'b0; cpu_ce = 1'b0; cpu_wrn = 1'b1; cpu_rdn = 1'b1;
        irq_n = 2'b11; rom_ok = 1'b1; rom_data = 8'h00;
        opl_dout = 8'h3C; opn_dout = 8'h4D; oki_dout = 8'h5E;
        snreq = 1'b0; latch = 8'h00; ram_wdata = 8'h00;
        test_reset();
        test_rom();
        test_decode();
        test_sx_priority();
        test_ram();
        test_fifo_basic();
        test_full_overflow();
        test_reset_mid_access();
        test_watchdog();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/jtcop_sndbus.md
# jtcop_sndbus

Parametrised sound-CPU bus controller for the HuC6280 sound subsystem. It decodes CPU accesses into device chip selects using an SX-latched, CE-cleared scheme, registers the read-data mux, and generates ROM wait states. It replaces the single main-to-sound command latch with a FIFO plus an NMI handshake, and merges NIRQ interrupt sources. It sits between the sound CPU, the FM/ADPCM wrapper, the sound RAM and the SDRAM ROM port.

## Interface
- FIFO_AW, 3: log2 of command FIFO depth (depth = 2^FIFO_AW).
- NIRQ, 2: number of active-low interrupt sources merged into irqn.
- WDOG_W, 4: width of the NMI watchdog counter.
- RAM_AW, 13: sound RAM address width.

- clk  in  1  system clock, 24 MHz
- rst  in  1  asynchronous, active-high reset
- cpu_a  in  21  CPU address
- cpu_sx  in  1  CPU address-valid strobe
- cpu_ce  in  1  CPU bus cycle end
- cpu_wrn, cpu_rdn  in  1 each  CPU write/read strobes, active low
- cpu_din  out  8  registered read data to the CPU
- waitn  out  1  CPU wait, low stalls
- nmi_n  out  1  CPU NMI
- irqn  out  1  AND of irq_n
- irq_n  in  NIRQ  device interrupt inputs
- rom_cs  out  1; rom_ok  in  1; rom_data  in  8
- ram_addr  out  RAM_AW; ram_we  out  1; ram_dout  in  8
- opl_cs, opn_cs, oki_cs  out  1 each; opl_dout, opn_dout, oki_dout  in  8 each
- snreq  in  1  main-CPU command strobe; a rising edge pushes latch
- latch  in  8  main-CPU command byte
- fifo_full  out  1; fifo_level  out  FIFO_AW+1
- overflow  out  1  sticky: a push was dropped
- status  out  8  {nmi_n, irqn, overflow, fifo_full, fifo_level[3:0] zero-extended or truncated}

## Operation
- Address map (cpu_a[20:16] page, cpu_a[15] half):
  - rom: page 0x00
  - opl: page 0x10, upper half
  - opn: page 0x11, upper half
  - oki: page 0x13, lower half
  - cmd (FIFO read): page 0x13, upper half
  - ram: page 0x1F
  - Any other address reads 0xFF.
- All selects are set on the clk following cpu_sx, from the decode. They clear on cpu_ce, unless cpu_sx is high in the same cycle, in which case cpu_sx wins.
- ram_we = ram select & ~cpu_wrn. ram_addr = cpu_a[RAM_AW-1:0].
- cpu_din is registered with priority ram > opn > opl > oki > cmd > rom > 0xFF.
- cmd returns the FIFO head. An empty-FIFO read returns the last popped byte (0x00 after reset).
- waitn is registered as !rom_cs || rom_ok.
- FIFO push: on a snreq rising edge (snreq is registered once for edge detection).
  - When full, the byte is dropped and overflow is set. overflow clears only on reset.
- FIFO pop: on cpu_ce when the cmd select is high and cpu_rdn is low. One pop per access.
- If a push and a pop occur in the same cycle, both take effect and the level is unchanged. The full case is allowed because the pop frees a slot first.
- Pointers wrap modulo 2^FIFO_AW. fifo_level runs 0..2^FIFO_AW.
- NMI FSM:
  - IDLE (nmi_n=1) → ASSERT when level>0.
  - ASSERT (nmi_n=0) → GAP on pop, or on watchdog expiry.
  - GAP (nmi_n=1) holds 2 clk, then → ASSERT if level>0, else → IDLE.

## Timing
- Reset values:
  - All selects 0; cpu_din 0xFF; waitn 1; nmi_n 1; irqn 1.
  - FIFO empty; fifo_full 0; overflow 0; watchdog all ones; FSM IDLE.
- Chip select rises 1 clk after cpu_sx. cpu_din is valid 1 clk after the select.
- The FIFO is first-word-fall-through: the head is valid on the cycle after the push.
- nmi_n falls 1 clk after level becomes non-zero. It rises 1 clk after the pop.
- irqn is combinational.
- Reset mid-access drops any pending pop and clears the FIFO.

## Configuration
- JTCOP_NMI_WDOG_EN defined:
  - In ASSERT, each irqn falling edge (irqn registered) decrements the watchdog.
  - Reaching 0 forces ASSERT → GAP without a pop and reloads the watchdog to all ones. The FIFO is untouched.
  - Entering ASSERT also reloads the watchdog.
- Undefined: the watchdog logic is absent and NMI is released only by a pop.

## Test plan
- Reset, then cpu_sx with cpu_a=0x000123 and rom_ok=0 → rom_cs=1, waitn=0. Drive rom_ok=1, rom_data=0x5A → waitn=1, cpu_din=0x5A. cpu_ce → rom_cs=0.
- Push 0x11, 0x22, 0x33 via snreq edges → nmi_n=0, level=3. Three cmd reads return 0x11, 0x22, 0x33. nmi_n shows a 2-clk high gap after each pop and ends high with level=0.
- With FIFO_AW=3, push 9 bytes → fifo_full=1, overflow=1, level=8. The 9th byte is absent from the reads.
- Push and cmd-pop in the same clk at level=8 → level stays 8, overflow stays 0.
- With JTCOP_NMI_WDOG_EN and WDOG_W=4, hold 1 byte unread and toggle irq_n[0] 15 times → nmi_n rises for 2 clk, then re-asserts. level is still 1.
- Write 0xA5 to 0x1F0010, then read it back → ram_we pulses once and cpu_din=0xA5. A read of 0x120000 returns 0xFF.
